// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared PIPE definitions for the PHY-side receiver-detection logic.
//   pipe_powerdown_e     - PIPE PowerDown encodings
//   RXSTATUS_RX_PRESENT  - RxStatus code the PHY reports when a receiver is present
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        P0  = 2'b00,
        P0S = 2'b01,
        P1  = 2'b10,
        P2  = 2'b11
    } pipe_powerdown_e;

    localparam logic [2:0] RXSTATUS_RX_PRESENT = 3'b011;

endpackage

// File: rtl/pipe_rx_detect_lane.sv
// pipe_rx_detect_lane: per-lane state of one receiver-detection attempt.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   abort          clear everything (detect stage disabled)
//   start          load pending/TxDetectRx from mask (request cycle)
//   mask           this lane takes part in the current attempt
//   active         sequencer is waiting for PhyStatus
//   expire         detect timeout reached this cycle
//   phystatus      PIPE PhyStatus for this lane
//   rxstatus       PIPE RxStatus for this lane, sampled only with PhyStatus
//   pending        lane still waiting for PhyStatus
//   result         1 = receiver detected in the last attempt
//   txdetectrx     PIPE TxDetectRx drive for this lane
//   hit            PhyStatus accepted this cycle
module pipe_rx_detect_lane
    import pcie_phy_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       abort,
    input  logic       start,
    input  logic       mask,
    input  logic       active,
    input  logic       expire,
    input  logic       phystatus,
    input  logic [2:0] rxstatus,
    output logic       pending,
    output logic       result,
    output logic       txdetectrx,
    output logic       hit
);

    // PhyStatus on a lane that is not waiting is ignored.
    assign hit = active & pending & phystatus;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending    <= 1'b0;
            result     <= 1'b0;
            txdetectrx <= 1'b0;
        end else if (abort) begin
            pending    <= 1'b0;
            result     <= 1'b0;
            txdetectrx <= 1'b0;
        end else if (start) begin
            pending    <= mask;
            result     <= 1'b0;
            txdetectrx <= mask;
        end else if (hit) begin
            // A PhyStatus arriving in the timeout cycle still counts.
            result     <= (rxstatus == RXSTATUS_RX_PRESENT);
            pending    <= 1'b0;
            txdetectrx <= 1'b0;
        end else if (active && expire && pending) begin
            result     <= 1'b0;
            pending    <= 1'b0;
            txdetectrx <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_rx_detect.sv
// pipe_rx_detect: PIPE-side receiver-detection sequencer feeding the LTSSM detect stage.
// Holds the PHY in P1 while enabled, pulses TxDetectRx per lane, collects PhyStatus/RxStatus
// and repeats the detection so the detect stage always sees a fresh lane_status_o.
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   en_i                detect stage active; low aborts and clears
//   txdetectrx_i        lane request mask (all-zero = all lanes)
//   lane_status_o       receiver present per lane (registered)
//   done_o              one-cycle pulse when lane_status_o is updated
//   timeout_o           sticky: a lane missed PhyStatus; cleared while en_i low
//   pipe_powerdown_o    PIPE PowerDown (P1 while enabled, else P0)
//   pipe_txdetectrx_o   PIPE TxDetectRx per lane
//   pipe_phystatus_i    PIPE PhyStatus per lane
//   pipe_rxstatus_i     PIPE RxStatus, lane l at [3l+:3]
module pipe_rx_detect
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_NUM_LANES  = 4,
    parameter int unsigned CLK_RATE       = 100,
    parameter int unsigned DET_TIMEOUT_US = 10,
    parameter int unsigned REPEAT_GAP     = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [MAX_NUM_LANES-1:0]     txdetectrx_i,
    output logic [MAX_NUM_LANES-1:0]     lane_status_o,
    output logic                         done_o,
    output logic                         timeout_o,
    output logic [1:0]                   pipe_powerdown_o,
    output logic [MAX_NUM_LANES-1:0]     pipe_txdetectrx_o,
    input  logic [MAX_NUM_LANES-1:0]     pipe_phystatus_i,
    input  logic [3*MAX_NUM_LANES-1:0]   pipe_rxstatus_i
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(CLK_RATE * DET_TIMEOUT_US - 1);
    localparam logic [31:0] GAP_LAST     = 32'(REPEAT_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_GAP
    } state_e;

    state_e                   state;
    logic [31:0]              timer;
    logic [31:0]              gap_timer;
    logic [MAX_NUM_LANES-1:0] mask;
    logic [MAX_NUM_LANES-1:0] req_mask;
    logic [MAX_NUM_LANES-1:0] pending;
    logic [MAX_NUM_LANES-1:0] result;
    logic [MAX_NUM_LANES-1:0] hit;
    logic [MAX_NUM_LANES-1:0] pending_left;
    logic                     abort;
    logic                     start;
    logic                     active;
    logic                     expire;

    assign req_mask     = (txdetectrx_i == '0) ? '1 : txdetectrx_i;
    assign abort        = ~en_i;
    assign start        = (state == ST_REQ);
    assign active       = (state == ST_WAIT);
    assign expire       = (timer >= TIMEOUT_LAST);
    // Lanes still waiting after this cycle's PhyStatus has been taken.
    assign pending_left = pending & ~hit;

    for (genvar l = 0; l < MAX_NUM_LANES; l++) begin : g_lane
        pipe_rx_detect_lane u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .abort      (abort),
            .start      (start),
            .mask       (mask[l]),
            .active     (active),
            .expire     (expire),
            .phystatus  (pipe_phystatus_i[l]),
            .rxstatus   (pipe_rxstatus_i[3*l +: 3]),
            .pending    (pending[l]),
            .result     (result[l]),
            .txdetectrx (pipe_txdetectrx_o[l]),
            .hit        (hit[l])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= ST_IDLE;
            timer            <= '0;
            gap_timer        <= '0;
            mask             <= '0;
            lane_status_o    <= '0;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
            pipe_powerdown_o <= P0;
        end else begin
            pipe_powerdown_o <= en_i ? P1 : P0;
            done_o           <= 1'b0;
            if (!en_i) begin
                state         <= ST_IDLE;
                timer         <= '0;
                gap_timer     <= '0;
                lane_status_o <= '0;
                timeout_o     <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        mask  <= req_mask;
                        state <= ST_REQ;
                    end
                    ST_REQ: begin
                        timer <= '0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (timer != '1) timer <= timer + 32'd1;
                        // Moving on the PhyStatus cycle keeps last PhyStatus -> done_o at 2.
                        if (pending_left == '0) begin
                            state <= ST_DONE;
                        end else if (expire) begin
                            timeout_o <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        lane_status_o <= (lane_status_o & ~mask) | (result & mask);
                        done_o        <= 1'b1;
                        gap_timer     <= '0;
                        state         <= ST_GAP;
                    end
                    ST_GAP: begin
                        if (gap_timer >= GAP_LAST) begin
                            state <= ST_IDLE;
                        end else if (gap_timer != '1) begin
                            gap_timer <= gap_timer + 32'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_rx_detect.sv
// tb_pipe_rx_detect: directed self-checking bench for pipe_rx_detect (4 lanes, 100 MHz, 10 us).
// Expected lane_status/timeout per detection round go into a scoreboard queue when the round
// is stimulated and are compared when done_o pulses.
module tb_pipe_rx_detect;

    logic        clk;
    logic        rst_ni;
    logic        en_i;
    logic [3:0]  txdetectrx_i;
    logic [3:0]  lane_status_o;
    logic        done_o;
    logic        timeout_o;
    logic [1:0]  pipe_powerdown_o;
    logic [3:0]  pipe_txdetectrx_o;
    logic [3:0]  pipe_phystatus_i;
    logic [11:0] pipe_rxstatus_i;

    typedef struct packed {
        logic [3:0] ls;
        logic       to;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_cmp = 0;
    int       n_err = 0;

    pipe_rx_detect #(
        .MAX_NUM_LANES  (4),
        .CLK_RATE       (100),
        .DET_TIMEOUT_US (10),
        .REPEAT_GAP     (64)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .txdetectrx_i      (txdetectrx_i),
        .lane_status_o     (lane_status_o),
        .done_o            (done_o),
        .timeout_o         (timeout_o),
        .pipe_powerdown_o  (pipe_powerdown_o),
        .pipe_txdetectrx_o (pipe_txdetectrx_o),
        .pipe_phystatus_i  (pipe_phystatus_i),
        .pipe_rxstatus_i   (pipe_rxstatus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after TxDetectRx has been seen asserted (t=0). Response r1 is driven at
    // t=d1, r2 at t=d2 (sampled on the following edge); done_o must be seen at t=exp_t.
    task automatic round(input string tag, input logic [3:0] mask,
                         input logic [3:0] r1, input int d1,
                         input logic [3:0] r2, input int d2,
                         input logic [11:0] rx, input logic [3:0] exp_ls,
                         input logic exp_to, input int exp_t);
        sb_item_t it;
        int       t;
        logic     stray;
        logic     seen;
        it.ls = exp_ls;
        it.to = exp_to;
        sb.push_back(it);
        check($sformatf("%s.txdet_on", tag), {28'd0, pipe_txdetectrx_o}, {28'd0, mask});
        check($sformatf("%s.pwr_p1", tag), {30'd0, pipe_powerdown_o}, 32'd2);
        stray = 1'b0;
        seen  = 1'b0;
        t     = 0;
        pipe_rxstatus_i = rx;
        while (!seen && t < 1200) begin
            pipe_phystatus_i = ((t == d1) ? r1 : 4'b0) | ((t == d2) ? r2 : 4'b0);
            tick();
            t++;
            pipe_phystatus_i = 4'b0;
            if ((pipe_txdetectrx_o & ~mask) != 4'b0) stray = 1'b1;
            if (done_o) seen = 1'b1;
        end
        check($sformatf("%s.done_seen", tag), {31'd0, seen}, 32'd1);
        check($sformatf("%s.latency", tag), t, exp_t);
        check($sformatf("%s.no_stray_txdet", tag), {31'd0, stray}, 32'd0);
        if (seen) begin
            it = sb.pop_front();
            check($sformatf("%s.lane_status", tag), {28'd0, lane_status_o}, {28'd0, it.ls});
            check($sformatf("%s.timeout", tag), {31'd0, timeout_o}, {31'd0, it.to});
            check($sformatf("%s.txdet_off", tag), {28'd0, pipe_txdetectrx_o}, 32'd0);
            tick();
            check($sformatf("%s.done_pulse", tag), {31'd0, done_o}, 32'd0);
        end
    endtask

    task automatic wait_txdet(input string tag, input int exp_t);
        int t = 0;
        while (pipe_txdetectrx_o == 4'b0 && t < 300) begin
            tick();
            t++;
        end
        check(tag, t, exp_t);
    endtask

    initial begin
        logic flag;
        rst_ni           = 1'b0;
        en_i             = 1'b0;
        txdetectrx_i     = 4'b0;
        pipe_phystatus_i = 4'b0;
        pipe_rxstatus_i  = 12'b0;
        #12;
        check("rst.lane_status", {28'd0, lane_status_o}, 32'd0);
        check("rst.done", {31'd0, done_o}, 32'd0);
        check("rst.timeout", {31'd0, timeout_o}, 32'd0);
        check("rst.pwr", {30'd0, pipe_powerdown_o}, 32'd0);
        check("rst.txdet", {28'd0, pipe_txdetectrx_o}, 32'd0);
        #5 rst_ni = 1'b1;
        tick();

        // All lanes, mask 0, every lane present.
        en_i = 1'b1;
        tick();
        check("all.txdet_lat1", {28'd0, pipe_txdetectrx_o}, 32'd0);
        tick();
        round("all", 4'hF, 4'hF, 3, 4'h0, -1, 12'h6DB, 4'hF, 1'b0, 5);

        // Mask 0011 while still enabled: lanes 2/3 keep the previous 1s.
        txdetectrx_i = 4'b0011;
        wait_txdet("gap1", 65);
        round("m3_keep", 4'h3, 4'h3, 5, 4'h0, -1, 12'h6C3, 4'b1101, 1'b0, 7);

        // Disable clears, then mask 0011 from a clean start.
        en_i = 1'b0;
        tick();
        check("dis.lane_status", {28'd0, lane_status_o}, 32'd0);
        check("dis.txdet", {28'd0, pipe_txdetectrx_o}, 32'd0);
        check("dis.pwr", {30'd0, pipe_powerdown_o}, 32'd0);
        en_i = 1'b1;
        tick();
        check("m3.txdet_lat1", {28'd0, pipe_txdetectrx_o}, 32'd0);
        tick();
        round("m3", 4'h3, 4'h3, 4, 4'h0, -1, 12'h6C3, 4'b0001, 1'b0, 6);

        // Lane 3 never answers.
        en_i = 1'b0;
        txdetectrx_i = 4'b0;
        tick();
        en_i = 1'b1;
        tick();
        tick();
        round("tmo", 4'hF, 4'b0111, 3, 4'h0, -1, 12'h6DB, 4'b0111, 1'b1, 1001);
        en_i = 1'b0;
        tick();
        check("tmo.sticky_clear", {31'd0, timeout_o}, 32'd0);

        // Lane 2 PhyStatus sampled on the timeout edge.
        en_i = 1'b1;
        tick();
        tick();
        round("coin", 4'hF, 4'b1011, 2, 4'b0100, 999, 12'h6DB, 4'hF, 1'b0, 1001);

        // Abort mid-wait on the repeat cycle.
        wait_txdet("gap2", 65);
        tick();
        tick();
        tick();
        en_i = 1'b0;
        tick();
        check("abort.txdet", {28'd0, pipe_txdetectrx_o}, 32'd0);
        check("abort.lane_status", {28'd0, lane_status_o}, 32'd0);
        check("abort.timeout", {31'd0, timeout_o}, 32'd0);
        flag = done_o;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_o) flag = 1'b1;
        end
        check("abort.no_done", {31'd0, flag}, 32'd0);

        // Asynchronous reset mid-wait, then restart with en_i held high.
        en_i = 1'b1;
        tick();
        tick();
        round("pre", 4'hF, 4'hF, 1, 4'h0, -1, 12'h6DB, 4'hF, 1'b0, 3);
        wait_txdet("gap3", 65);
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check("arst.lane_status", {28'd0, lane_status_o}, 32'd0);
        check("arst.txdet", {28'd0, pipe_txdetectrx_o}, 32'd0);
        check("arst.pwr", {30'd0, pipe_powerdown_o}, 32'd0);
        check("arst.done", {31'd0, done_o}, 32'd0);
        check("arst.timeout", {31'd0, timeout_o}, 32'd0);
        #2 rst_ni = 1'b1;
        tick();
        check("arst.txdet_lat1", {28'd0, pipe_txdetectrx_o}, 32'd0);
        tick();
        check("arst.txdet_lat2", {28'd0, pipe_txdetectrx_o}, 32'hF);

        en_i = 1'b0;
        tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
